// File: rtl/fifo_queue_if.sv
// Handshake/status bundle between a producer/consumer pair and fifo_queue.
// slave modport: the FIFO side (takes requests, drives data and status).
// master modport: the user side (drives clear/write/read requests, observes data and status).
interface fifo_queue_if #(
    parameter int WIDTH_DATA = 8,
    parameter int DEPTH      = 8
);
    localparam int WIDTH_LENGTH = $clog2(DEPTH + 1);

    logic                    clear;
    logic                    write_enable;
    logic [WIDTH_DATA-1:0]   write_data;
    logic                    read_enable;
    logic [WIDTH_DATA-1:0]   read_data;
    logic                    read_valid;
    logic                    is_empty;
    logic                    is_full;
    logic                    almost_full;
    logic                    almost_empty;
    logic [WIDTH_LENGTH-1:0] length;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output clear, write_enable, write_data, read_enable,
        input  read_data, read_valid, is_empty, is_full, almost_full, almost_empty,
               length, overflow, underflow
    );

    modport slave (
        input  clear, write_enable, write_data, read_enable,
        output read_data, read_valid, is_empty, is_full, almost_full, almost_empty,
               length, overflow, underflow
    );
endinterface

// File: rtl/fifo_queue.sv
// Purpose: synchronous single-clock FIFO of any depth >= 2, with thresholds, sticky errors and flush.
// Latency: write-to-read 1 cycle; registered read data 1 cycle after pop (0 cycles with FIFO_QUEUE_FWFT_EN).
// Backpressure: writes to a full queue are rejected unless a read is accepted in the same cycle; rejects set sticky flags.
//
// Ports: clock_i (rising edge), reset_i (synchronous, active-high), q_if (fifo_queue_if.slave):
//   clear/write_enable/write_data/read_enable in; read_data/read_valid/status flags/length/overflow/underflow out.
// Optional feature: define FIFO_QUEUE_FWFT_EN for first-word-fall-through reads.
module fifo_queue #(
    parameter int WIDTH_DATA         = 8,
    parameter int DEPTH              = 8,
    parameter int ALMOST_FULL_LEVEL  = DEPTH - 1,
    parameter int ALMOST_EMPTY_LEVEL = 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    fifo_queue_if.slave q_if
);
    localparam int WIDTH_ADDR   = $clog2(DEPTH);
    localparam int WIDTH_LENGTH = $clog2(DEPTH + 1);
    localparam logic [WIDTH_ADDR-1:0]   ADDR_LAST   = WIDTH_ADDR'(DEPTH - 1);
    localparam logic [WIDTH_ADDR-1:0]   ADDR_ONE    = WIDTH_ADDR'(1);
    localparam logic [WIDTH_LENGTH-1:0] LENGTH_FULL = WIDTH_LENGTH'(DEPTH);
    localparam logic [WIDTH_LENGTH-1:0] LENGTH_ONE  = WIDTH_LENGTH'(1);

    logic [WIDTH_DATA-1:0]   mem_q [DEPTH];
    logic [WIDTH_ADDR-1:0]   wr_addr_q, wr_addr_d;
    logic [WIDTH_ADDR-1:0]   rd_addr_q, rd_addr_d;
    logic [WIDTH_LENGTH-1:0] length_q, length_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;
    logic                    is_empty, is_full;
    logic                    read_ok, write_ok;

    assign is_empty = (length_q == '0);
    assign is_full  = (length_q == LENGTH_FULL);

    // A full queue still accepts a write when a pop frees the slot in the same cycle.
    assign read_ok  = q_if.read_enable & ~is_empty;
    assign write_ok = q_if.write_enable & (~is_full | read_ok);

    always_comb begin
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        length_d    = length_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (q_if.clear) begin
            wr_addr_d   = '0;
            rd_addr_d   = '0;
            length_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            // Explicit wrap so that non-power-of-two depths index correctly.
            if (write_ok) wr_addr_d = (wr_addr_q == ADDR_LAST) ? '0 : wr_addr_q + ADDR_ONE;
            if (read_ok)  rd_addr_d = (rd_addr_q == ADDR_LAST) ? '0 : rd_addr_q + ADDR_ONE;
            case ({write_ok, read_ok})
                2'b10:   length_d = length_q + LENGTH_ONE;
                2'b01:   length_d = length_q - LENGTH_ONE;
                default: length_d = length_q;
            endcase
            overflow_d  = overflow_q  | (q_if.write_enable & ~write_ok);
            underflow_d = underflow_q | (q_if.read_enable  & ~read_ok);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            length_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            length_q    <= length_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset or flushed; only the pointers define what is live.
    always_ff @(posedge clock_i) begin
        if (!reset_i && !q_if.clear && write_ok) begin
            mem_q[wr_addr_q] <= q_if.write_data;
        end
    end

`ifdef FIFO_QUEUE_FWFT_EN
    // Head word is presented combinationally; read_enable acts as the pop acknowledge.
    assign q_if.read_data  = is_empty ? '0 : mem_q[rd_addr_q];
    assign q_if.read_valid = ~is_empty;
`else
    logic [WIDTH_DATA-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (q_if.clear) begin
            rd_data_d  = '0;
        end else if (read_ok) begin
            rd_data_d  = mem_q[rd_addr_q];
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign q_if.read_data  = rd_data_q;
    assign q_if.read_valid = rd_valid_q;
`endif

    assign q_if.is_empty     = is_empty;
    assign q_if.is_full      = is_full;
    assign q_if.almost_full  = (int'(length_q) >= ALMOST_FULL_LEVEL);
    assign q_if.almost_empty = (int'(length_q) <= ALMOST_EMPTY_LEVEL);
    assign q_if.length       = length_q;
    assign q_if.overflow     = overflow_q;
    assign q_if.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_queue.sv
// Self-checking bench for fifo_queue (DEPTH=5, almost_full at 4, almost_empty at 1).
// A queue-based reference model predicts occupancy, flags and popped words; a monitor checks popped data.
module tb_fifo_queue;
    localparam int W  = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_queue_if #(.WIDTH_DATA(W), .DEPTH(D)) q_if ();

    fifo_queue #(
        .WIDTH_DATA(W), .DEPTH(D), .ALMOST_FULL_LEVEL(AF), .ALMOST_EMPTY_LEVEL(AE)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .q_if    (q_if.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [W-1:0] model_q[$];   // reference queue contents
    logic [W-1:0] exp_q[$];     // words expected to come out, in order
    bit           m_ovf, m_unf, m_rvld;
    logic [W-1:0] m_rdat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int n;
        n = model_q.size();
        check("length",       32'(q_if.length), n);
        check("is_empty",     q_if.is_empty,     n == 0);
        check("is_full",      q_if.is_full,      n == D);
        check("almost_full",  q_if.almost_full,  n >= AF);
        check("almost_empty", q_if.almost_empty, n <= AE);
        check("overflow",     q_if.overflow,     m_ovf);
        check("underflow",    q_if.underflow,    m_unf);
`ifdef FIFO_QUEUE_FWFT_EN
        check("read_valid",   q_if.read_valid,   n != 0);
        if (n != 0) check("head_data", q_if.read_data, model_q[0]);
`else
        check("read_valid",   q_if.read_valid,   m_rvld);
        check("read_data",    q_if.read_data,    m_rdat);
`endif
    endtask

    // One clock of stimulus; the model is advanced to the post-edge state before the edge.
    task automatic cycle(input bit r, input bit c, input bit we, input logic [W-1:0] wd, input bit re);
        bit rok, wok;
        rst               = r;
        q_if.clear        = c;
        q_if.write_enable = we;
        q_if.write_data   = wd;
        q_if.read_enable  = re;
        if (r || c) begin
            model_q.delete();
            m_ovf  = 0;
            m_unf  = 0;
            m_rvld = 0;
            m_rdat = '0;
        end else begin
            rok    = re && (model_q.size() > 0);
            wok    = we && ((model_q.size() < D) || rok);
            m_rvld = rok;
            if (rok) begin
                m_rdat = model_q.pop_front();
                exp_q.push_back(m_rdat);
            end
            if (wok) model_q.push_back(wd);
            if (we && !wok) m_ovf = 1;
            if (re && !rok) m_unf = 1;
        end
        @(posedge clk);
        #1;
        check_status();
    endtask

    // Scoreboard monitor: pops one expected word each time the DUT delivers one.
    always @(negedge clk) begin
`ifdef FIFO_QUEUE_FWFT_EN
        if (!rst && !q_if.clear && q_if.read_enable && q_if.read_valid) begin
`else
        if (q_if.read_valid) begin
`endif
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no word at %0t", q_if.read_data, $time);
            end else begin
                check("rd_order", q_if.read_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit r, c, we, re;
        int wprob;
        q_if.clear        = 1'b0;
        q_if.write_enable = 1'b0;
        q_if.write_data   = '0;
        q_if.read_enable  = 1'b0;

        cycle(1, 0, 0, '0, 0);
        cycle(1, 0, 0, '0, 0);

        // Fill to full, then one rejected write.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'(8'h11 + i), 0);
        cycle(0, 0, 1, 8'h99, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0, 1);
        cycle(0, 1, 0, '0, 0);

        // Three rounds across both pointer wraps.
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'(8'h20 + rnd * 16 + i), 0);
            for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0, 1);
        end

        // Simultaneous read/write on a full queue.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'(8'h40 + i), 0);
        cycle(0, 0, 1, 8'hAA, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0, 1);

        // Empty queue: lone read underflows, read+write accepts only the write.
        cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 1, 8'h3C, 1);
        cycle(0, 0, 0, '0, 1);
        cycle(0, 1, 0, '0, 0);

        // Threshold walk 0..5, an extra write to overflow, then clear with requests pending.
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 8'(8'h60 + i), 0);
        cycle(0, 1, 1, 8'h77, 1);
        cycle(0, 0, 0, '0, 0);

        // Single word into an empty queue, observed before and after the pop.
        cycle(0, 0, 1, 8'h5A, 0);
        cycle(0, 0, 0, '0, 0);
        cycle(0, 0, 0, '0, 1);

        // Randomized traffic with biased phases, occasional clear and reset.
        for (int n = 0; n < 800; n++) begin
            wprob = ((n / 40) % 2 == 0) ? 75 : 25;
            r  = ($urandom_range(0, 149) == 0);
            c  = ($urandom_range(0, 59) == 0);
            we = ($urandom_range(0, 99) < wprob);
            re = ($urandom_range(0, 99) < (100 - wprob));
            cycle(r, c, we, 8'($urandom), re);
        end

        for (int i = 0; i < D + 1; i++) cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 0, '0, 0);
        cycle(0, 0, 0, '0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
